// File: rtl/bcd_scan_display.sv
// Scans four held BCD digits onto a 4-digit common-anode 7-segment display.
// The digits are snapshotted once per frame, so a frame never mixes old and new values.
module bcd_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] thousand,
  input  logic [3:0] hundred,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  input  logic       freeze,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  snap_q, snap_d;  // [3] = thousands ... [0] = ones
  logic             tick;
  logic             wrap;
  logic [3:0]       blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // non-BCD code shows a minus sign
    endcase
    return s;
  endfunction

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    wrap   = tick && (idx_q == 2'd3);
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    if (wrap && !freeze) snap_d = {thousand, hundred, ten, one};
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      // NOTE: the snapshot is reset because it drives the display directly after reset.
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    blank    = '0;
    blank[3] = (BLANK_LZ != 0) && (snap_q[3] == 4'd0);
    blank[2] = blank[3] && (snap_q[2] == 4'd0);
    blank[1] = blank[2] && (snap_q[1] == 4'd0);
    frame    = wrap;
    an       = ~(4'b0001 << idx_q);
    seg      = blank[idx_q] ? 7'b1111111 : seg_decode(snap_q[idx_q]);
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus randomized
// stimulus against a frame-level reference model (SCAN_DIV=4 and SCAN_DIV=1).
`timescale 1ns/100ps
module tb_bcd_scan_display;

  logic       clk;
  logic       rst;
  logic [3:0] thousand, hundred, ten, one;
  logic       freeze;
  logic [3:0] an, an_nb, an_f;
  logic [6:0] seg, seg_nb, seg_f;
  logic       frame, frame_nb, frame_f;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  bcd_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .thousand(thousand), .hundred(hundred), .ten(ten), .one(one),
    .freeze(freeze), .an(an), .seg(seg), .frame(frame));

  bcd_scan_display #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .thousand(thousand), .hundred(hundred), .ten(ten), .one(one),
    .freeze(freeze), .an(an_nb), .seg(seg_nb), .frame(frame_nb));

  bcd_scan_display #(.SCAN_DIV(1), .BLANK_LZ(1)) dut_f (
    .clk(clk), .rst(rst), .thousand(thousand), .hundred(hundred), .ten(ten), .one(one),
    .freeze(freeze), .an(an_f), .seg(seg_f), .frame(frame_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges since reset release and the digits latched at each frame wrap.
  int         edges;
  logic [15:0] snap4, snap1;  // {thousand, hundred, ten, one}

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges <= 0;
      snap4 <= '0;
      snap1 <= '0;
    end else begin
      edges <= edges + 1;
      if ((edges % 16) == 15 && !freeze) snap4 <= {thousand, hundred, ten, one};
      if ((edges % 4) == 3 && !freeze)   snap1 <= {thousand, hundred, ten, one};
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (d > 4'd9) return 7'b0111111;
    return tbl[d];
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] s, input int idx, input bit blank_en);
    int lead;
    lead = 0;
    // count leading zero digits from the top, never counting the ones digit
    for (int i = 3; i >= 1; i--)
      if (s[i*4 +: 4] == 4'd0 && lead == 3 - i) lead++;
    if (blank_en && idx >= 4 - lead) return 7'b1111111;
    return glyph(s[idx*4 +: 4]);
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    logic [3:0] a;
    a      = 4'b1111;
    a[idx] = 1'b0;
    return a;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("an_div4",    {28'd0, an},      {28'd0, exp_an((edges / 4) % 4)});
      check("seg_div4",   {25'd0, seg},     {25'd0, exp_seg(snap4, (edges / 4) % 4, 1'b1)});
      check("frame_div4", {31'd0, frame},   {31'd0, (edges % 16) == 15});
      check("seg_noblank",{25'd0, seg_nb},  {25'd0, exp_seg(snap4, (edges / 4) % 4, 1'b0)});
      check("an_div1",    {28'd0, an_f},    {28'd0, exp_an(edges % 4)});
      check("seg_div1",   {25'd0, seg_f},   {25'd0, exp_seg(snap1, edges % 4, 1'b1)});
      check("frame_div1", {31'd0, frame_f}, {31'd0, (edges % 4) == 3});
    end
  end

  task automatic run_to(input int e);
    int k;
    k = 0;
    while (edges != e && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (edges != e) check("run_to_timeout", edges, e);
  endtask

  task automatic set_digits(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                            input logic [3:0] o);
    thousand = t; hundred = h; ten = te; one = o;
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 9) < 4) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst    = 1'b0;
    freeze = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    #1 rst = 1'b1;
    #1;
    check("reset_an",    {28'd0, an},    32'b1110);
    check("reset_seg",   {25'd0, seg},   32'b1000000);
    check("reset_frame", {31'd0, frame}, 32'd0);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    run_to(4);  check("step_an_4",  {28'd0, an}, 32'b1101);
    run_to(8);  check("step_an_8",  {28'd0, an}, 32'b1011);
    run_to(12); check("step_an_12", {28'd0, an}, 32'b0111);
    run_to(15); check("frame_c15",  {31'd0, frame}, 32'd1);

    run_to(16); check("d1234_i0", {25'd0, seg}, 32'b0011001);
    run_to(20); check("d1234_i1", {25'd0, seg}, 32'b0110000);
    run_to(24); check("d1234_i2", {25'd0, seg}, 32'b0100100);
    run_to(28); check("d1234_i3", {25'd0, seg}, 32'b1111001);

    set_digits(4'd0, 4'd0, 4'd7, 4'd0);
    run_to(32); check("blank_i0", {25'd0, seg}, 32'b1000000);
    run_to(36); check("blank_i1", {25'd0, seg}, 32'b1111000);
    run_to(40); check("blank_i2", {25'd0, seg}, 32'b1111111);
    run_to(44); check("blank_i3", {25'd0, seg}, 32'b1111111);
    check("noblank_i3", {25'd0, seg_nb}, 32'b1000000);

    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run_to(48); check("frz_pre_i0", {25'd0, seg}, 32'b0011001);
    freeze = 1'b1;
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    run_to(64); check("frz_hold_i0", {25'd0, seg}, 32'b0011001);
    freeze = 1'b0;
    run_to(80); check("unfrz_i0", {25'd0, seg}, 32'b0010000);
    run_to(84); check("unfrz_i1", {25'd0, seg}, 32'b0010000);
    run_to(88); check("unfrz_i2", {25'd0, seg}, 32'b0010000);
    run_to(92); check("unfrz_i3", {25'd0, seg}, 32'b0010000);

    set_digits(4'd0, 4'd0, 4'hC, 4'd0);
    run_to(96);  check("inv_i0", {25'd0, seg}, 32'b1000000);
    run_to(100); check("inv_i1", {25'd0, seg}, 32'b0111111);
    run_to(104); check("inv_i2", {25'd0, seg}, 32'b1111111);
    run_to(108); check("inv_i3", {25'd0, seg}, 32'b1111111);

    run_to(120);
    check("midrst_idx2", {28'd0, an}, 32'b1011);
    #1   rst = 1'b1;
    #0.5;
    check("midrst_an",    {28'd0, an},    32'b1110);
    check("midrst_seg",   {25'd0, seg},   32'b1000000);
    check("midrst_frame", {31'd0, frame}, 32'd0);
    #0.5 rst = 1'b0;
    run_to(4);
    check("midrst_an_4",  {28'd0, an},  32'b1101);
    check("midrst_seg_4", {25'd0, seg}, 32'b1111111);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
      freeze = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
